// File: rtl/bel_fft_avl_ram_slave.sv
// -----------------------------------------------------------------------------
// bel_fft_avl_ram_slave
//
// Avalon-MM pipelined slave with an internal word-addressed sample RAM. It
// answers the FFT core's master port with a fixed read latency and a bounded
// number of outstanding reads.
//
// Optional feature: define BEL_FFT_AVL_RAM_STALL_EN to add a 16-bit LFSR that
// randomly forces waitrequest high. This exercises master stall handling.
// Without the macro, waitrequest depends only on the pending-read limit.
//
// Parameters:
//   DWIDTH       data width in bits (multiple of 8)
//   BCNT         byteenable width (DWIDTH/8)
//   AWIDTH       word address width, RAM depth 2**AWIDTH
//   READ_LATENCY accept-to-readdatavalid latency in cycles (1..8)
//   MAX_PENDING  maximum accepted-but-unreturned reads (1..15)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   address        word address
//   writedata      write data
//   byteenable     per-byte write enable (ignored for reads)
//   read / write   request strobes
//   waitrequest    combinational stall; a request is accepted only when low
//   readdata       returned read data, holds its value between returns
//   readdatavalid  one-cycle pulse per returned read
//   protocol_err_o sticky flag, set when read and write are high together
// -----------------------------------------------------------------------------
module bel_fft_avl_ram_slave #(
  parameter int DWIDTH       = 32,
  parameter int BCNT         = DWIDTH / 8,
  parameter int AWIDTH       = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] address,
  input  logic [DWIDTH-1:0] writedata,
  input  logic [BCNT-1:0]   byteenable,
  input  logic              read,
  input  logic              write,
  output logic              waitrequest,
  output logic [DWIDTH-1:0] readdata,
  output logic              readdatavalid,
  output logic              protocol_err_o
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [DWIDTH-1:0]       mem_q [DEPTH];

  // Latency pipeline: stage READ_LATENCY-1 drives the outputs.
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] vld_d;
  logic [DWIDTH-1:0]       dat_q [READ_LATENCY];

  logic [PEND_W-1:0]       pend_q;
  logic [PEND_W-1:0]       pend_d;
  logic                    err_q;
  logic                    err_d;

  logic                    stall;
  logic                    ret;
  logic                    pend_full;
  logic                    acc_rd;
  logic                    acc_wr;

  // ---------------------------------------------------------------------------
  // Optional random stall source
  // ---------------------------------------------------------------------------
`ifdef BEL_FFT_AVL_RAM_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci form, taps 16,14,13,11 (bits 15,13,12,10).
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign ret       = vld_q[READ_LATENCY-1];
  // A return in this cycle frees a slot, so a new read can take its place.
  assign pend_full = (pend_q == PEND_W'(MAX_PENDING)) && !ret;

  assign waitrequest = (read & pend_full) | stall;
  assign acc_wr      = write & ~waitrequest;
  // When read and write collide, the write wins and the read is dropped.
  assign acc_rd      = read & ~write & ~waitrequest;

  // ---------------------------------------------------------------------------
  // Pending-read counter and protocol error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    if (acc_rd && !ret) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!acc_rd && ret) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    err_d = err_q | (read & write);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port with byte enables (contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (acc_wr) begin
      for (int b = 0; b < BCNT; b++) begin
        if (byteenable[b]) begin
          mem_q[address][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline
  // ---------------------------------------------------------------------------
  assign vld_d[0] = acc_rd;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_vld_shift
    assign vld_d[gi] = vld_q[gi-1];
  end

  // Data stages load only when a valid word arrives. The output stage
  // therefore holds the last returned word between returns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (acc_rd) begin
        dat_q[0] <= mem_q[address];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign readdata       = dat_q[READ_LATENCY-1];
  assign readdatavalid  = vld_q[READ_LATENCY-1];
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_bel_fft_avl_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_bel_fft_avl_ram_slave
//
// Drives two slaves from one shared stimulus stream:
//   dut0: defaults (READ_LATENCY=2, MAX_PENDING=4)
//   dut1: READ_LATENCY=3, MAX_PENDING=1
// Each slave has its own behavioural model. The model keeps a word array for
// the RAM and a calendar of scheduled returns indexed by cycle number. The
// model is checked against the outputs every cycle. Directed scenarios also
// compare observed outputs with fixed constants.
// -----------------------------------------------------------------------------
module tb_bel_fft_avl_ram_slave;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int L0  = 2;
  localparam int MP0 = 4;
  localparam int L1  = 3;
  localparam int MP1 = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    be    = '0;

  logic [1:0]    wreq;
  logic [1:0]    rdv;
  logic [1:0]    perr;
  logic [DW-1:0] rdata [2];

  always #5 clk = ~clk;

  bel_fft_avl_ram_slave #(
    .DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(L0), .MAX_PENDING(MP0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .address(addr), .writedata(wdata),
    .byteenable(be), .read(rd), .write(wr), .waitrequest(wreq[0]),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .protocol_err_o(perr[0])
  );

  bel_fft_avl_ram_slave #(
    .DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(L1), .MAX_PENDING(MP1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .address(addr), .writedata(wdata),
    .byteenable(be), .read(rd), .write(wr), .waitrequest(wreq[1]),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .protocol_err_o(perr[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_m   [2][1024];
  bit            sched_v [2][64];
  logic [DW-1:0] sched_d [2][64];
  int            pend_m  [2];
  bit            err_m   [2];
  logic [DW-1:0] last_m  [2];
  bit            rd_acc_m[2];

  // Observed-output bookkeeping for the directed checks.
  int            obs_rets [2];
  logic [DW-1:0] obs_last [2];
  int            obs_cyc  [2];
  bit            wait_seen[2];
  int            run_cur, run_max;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle of the model for slave k. Called mid-cycle, after inputs settle.
  task automatic model_eval(input int k);
    int  lat, mp, idx, j;
    bit  exp_ret, exp_wait, a_rd, a_wr;
    lat = (k == 0) ? L0 : L1;
    mp  = (k == 0) ? MP0 : MP1;
    idx = cyc % 64;
    exp_ret = sched_v[k][idx];

    if (rdv[k]) begin
      obs_rets[k]++;
      obs_last[k] = rdata[k];
      obs_cyc[k]  = cyc;
    end
    if (k == 0) begin
      run_cur = rdv[0] ? run_cur + 1 : 0;
      if (run_cur > run_max) run_max = run_cur;
    end
    wait_seen[k] = wreq[k];

    chk($sformatf("rdv%0d", k), {31'd0, rdv[k]}, {31'd0, exp_ret});
    if (exp_ret) begin
      chk($sformatf("rdata%0d", k), rdata[k], sched_d[k][idx]);
      $display("ret dut%0d cyc=%0d data=%h", k, cyc, sched_d[k][idx]);
      last_m[k] = sched_d[k][idx];
      sched_v[k][idx] = 1'b0;
    end else begin
      chk($sformatf("rdata_hold%0d", k), rdata[k], last_m[k]);
    end

    // A slot frees up in the same cycle a return is delivered.
    exp_wait = rd && (pend_m[k] == mp) && !exp_ret;
    chk($sformatf("waitreq%0d", k), {31'd0, wreq[k]}, {31'd0, exp_wait});
    chk($sformatf("perr%0d", k), {31'd0, perr[k]}, {31'd0, err_m[k]});

    a_wr = wr && !exp_wait;
    a_rd = rd && !wr && !exp_wait;
    if (a_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[k][addr][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (a_rd) begin
      j = (cyc + lat) % 64;
      sched_v[k][j] = 1'b1;
      sched_d[k][j] = mem_m[k][addr];
    end
    pend_m[k] = pend_m[k] + (a_rd ? 1 : 0) - (exp_ret ? 1 : 0);
    if (rd && wr) err_m[k] = 1'b1;
    rd_acc_m[k] = a_rd;
  endtask

  // Caller sets inputs at the falling edge. One clock cycle then passes.
  task automatic step();
    #1;
    model_eval(0);
    model_eval(1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    for (int k = 0; k < 2; k++) begin
      pend_m[k] = 0;
      err_m[k]  = 1'b0;
      last_m[k] = '0;
      for (int i = 0; i < 64; i++) sched_v[k][i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] b);
    rd = 1'b0; wr = 1'b1; addr = AW'(a); wdata = d; be = b;
    step();
    wr = 1'b0;
  endtask

  // Holds read until dut0 accepts it. Returns the accept cycle.
  task automatic do_read(input int a, output int acc_cyc);
    int t;
    t = 0;
    acc_cyc = -1;
    rd = 1'b1; wr = 1'b0; addr = AW'(a);
    do begin
      acc_cyc = cyc;
      step();
      t++;
    end while (!rd_acc_m[0] && t < 20);
    rd = 1'b0;
    if (!rd_acc_m[0]) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, nwait, a;
    run_cur = 0; run_max = 0;
    for (int k = 0; k < 2; k++) begin
      obs_rets[k] = 0; obs_last[k] = '0; obs_cyc[k] = 0;
    end

    do_reset();
    #1;
    chk("rst_rdv", {31'd0, rdv[0]}, 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_perr", {31'd0, perr[0]}, 32'd0);
    chk("rst_rdv1", {31'd0, rdv[1]}, 32'd0);
    @(negedge clk);

    // Preload the working address range.
    for (int i = 0; i < 32; i++) do_write(i, 32'hA000_0000 + i, 4'hF);
    idle(2);

    // Full write, then read back after exactly two cycles.
    do_write(5, 32'hDEAD_BEEF, 4'hF);
    do_read(5, acc);
    idle(5);
    chk("t1_data", obs_last[0], 32'hDEAD_BEEF);
    chk("t1_latency", obs_cyc[0] - acc, 32'd2);

    // Byte-enable merge.
    do_write(7, 32'h1122_3344, 4'hF);
    do_write(7, 32'hAABB_CCDD, 4'b0101);
    do_read(7, acc);
    idle(5);
    chk("t2_merge", obs_last[0], 32'h11BB_33DD);

    // dut1: hold read over addrs 0..3 for 12 cycles.
    idle(6);
    base = obs_rets[1]; nwait = 0; a = 0;
    rd = 1'b1; wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      addr = AW'(a & 3);
      step();
      if (wait_seen[1]) nwait++;
      if (rd_acc_m[1]) a++;
    end
    rd = 1'b0;
    idle(6);
    chk("t3_waits", nwait, 32'd8);
    chk("t3_rets", obs_rets[1] - base, 32'd4);
    chk("t3_last", obs_last[1], 32'hA000_0003);

    // dut0: burst of 8 back-to-back reads.
    idle(6);
    base = obs_rets[0]; nwait = 0; run_max = 0;
    rd = 1'b1; wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = AW'(16 + i);
      step();
      if (wait_seen[0]) nwait++;
    end
    rd = 1'b0;
    idle(6);
    chk("t4_waits", nwait, 32'd0);
    chk("t4_rets", obs_rets[0] - base, 32'd8);
    chk("t4_run", run_max, 32'd8);
    chk("t4_last", obs_last[0], 32'hA000_0017);

    // Reset with two reads in flight.
    idle(6);
    rd = 1'b1; wr = 1'b0; addr = AW'(1); step();
    addr = AW'(2); step();
    rd = 1'b0;
    do_reset();
    base = obs_rets[0];
    idle(6);
    chk("t5_dropped", obs_rets[0] - base, 32'd0);
    do_read(1, acc);
    idle(5);
    chk("t5_retained", obs_last[0], 32'hA000_0001);

    // Simultaneous read and write.
    idle(4);
    base = obs_rets[0];
    rd = 1'b1; wr = 1'b1; addr = AW'(3); wdata = 32'h5; be = 4'hF;
    step();
    rd = 1'b0; wr = 1'b0;
    idle(4);
    chk("t6_perr", {31'd0, perr[0]}, 32'd1);
    chk("t6_noret", obs_rets[0] - base, 32'd0);
    do_read(3, acc);
    idle(5);
    chk("t6_data", obs_last[0], 32'h5);
    chk("t6_perr_sticky", {31'd0, perr[0]}, 32'd1);
    do_reset();
    #1;
    chk("t6_perr_clr", {31'd0, perr[0]}, 32'd0);
    @(negedge clk);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      rd    = ($urandom_range(0, 2) == 0);
      wr    = ($urandom_range(0, 3) == 0) && ($urandom_range(0, 7) != 0 || !rd);
      addr  = AW'($urandom_range(0, 31));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      step();
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
